tone_decoder: RTL and testbench

//  Receive-side counterpart of the buzzer tone path. Samples a square-wave tone (bzin loopback or a

---
 rtl/tone_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_tone_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// Tone decoder: measures the rising-edge period of a square-wave tone in clock cycles
// and locks onto one of four notes (00 C4, 01 E4, 10 Ab4, 11 C5) after MATCH_CNT
// consecutive in-band periods of the same note.
module tone_decoder #(
  parameter int unsigned P_C4      = 191571,
  parameter int unsigned P_E4      = 151976,
  parameter int unsigned P_AB4     = 120482,
  parameter int unsigned P_C5      = 95602,
  parameter int unsigned TOL       = 4000,
  parameter int unsigned MATCH_CNT = 3,
  parameter int unsigned TIMEOUT   = 250000
) (
  input  logic        clk_50MHz,
  input  logic        reset_button,
  input  logic        tone_in,
  output logic [1:0]  note,
  output logic        note_valid,
  output logic [17:0] period,
  output logic        period_stb
);

  localparam logic [17:0] TimeoutCnt = 18'(TIMEOUT);
  localparam logic [2:0]  MatchCnt   = 3'(MATCH_CNT);

  // Inclusive band limits around each nominal period
  localparam logic [17:0] LoC4  = 18'(P_C4 - TOL);
  localparam logic [17:0] HiC4  = 18'(P_C4 + TOL);
  localparam logic [17:0] LoE4  = 18'(P_E4 - TOL);
  localparam logic [17:0] HiE4  = 18'(P_E4 + TOL);
  localparam logic [17:0] LoAb4 = 18'(P_AB4 - TOL);
  localparam logic [17:0] HiAb4 = 18'(P_AB4 + TOL);
  localparam logic [17:0] LoC5  = 18'(P_C5 - TOL);
  localparam logic [17:0] HiC5  = 18'(P_C5 + TOL);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StTrack,
    StLock
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_prev;
  logic        r_edge;
  logic [17:0] r_cnt;
  logic [2:0]  r_run;
  logic [2:0]  w_run_d;
  logic [1:0]  r_cand;
  logic [1:0]  w_cand_d;
  logic [1:0]  r_note;
  logic [1:0]  w_note_d;
  logic        r_valid;
  logic        w_valid_d;
  logic [17:0] r_period;
  logic [17:0] w_period_d;
  logic        r_stb;
  logic        w_stb_d;

  logic        w_hit;
  logic [1:0]  w_cls;
  logic        w_timeout;
  logic [2:0]  w_run_inc;

  // Synchronise the tone, then register a one-cycle rising-edge pulse
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_edge      <= 1'b0;
    end else begin
      r_sync1     <= tone_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_edge      <= r_sync2 & ~r_sync_prev;
    end
  end

  // Edge-to-edge cycle counter, restarts at 1 on each edge and saturates at TIMEOUT
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      r_cnt <= '0;
    end else if (r_edge) begin
      r_cnt <= 18'd1;
    end else if (r_cnt != TimeoutCnt) begin
      r_cnt <= r_cnt + 18'd1;
    end
  end

  // Classify the count at the current edge into a note band
  always_comb begin
    w_hit = 1'b1;
    w_cls = 2'b00;
    if (r_cnt >= LoC4 && r_cnt <= HiC4) begin
      w_cls = 2'b00;
    end else if (r_cnt >= LoE4 && r_cnt <= HiE4) begin
      w_cls = 2'b01;
    end else if (r_cnt >= LoAb4 && r_cnt <= HiAb4) begin
      w_cls = 2'b10;
    end else if (r_cnt >= LoC5 && r_cnt <= HiC5) begin
      w_cls = 2'b11;
    end else begin
      w_hit = 1'b0;
    end
  end

  assign w_timeout = (r_cnt == TimeoutCnt) && (r_state != StIdle);
  assign w_run_inc = r_run + 3'd1;

  // Next-state logic: timeout has priority over a coincident edge
  always_comb begin
    w_state_d  = r_state;
    w_run_d    = r_run;
    w_cand_d   = r_cand;
    w_note_d   = r_note;
    w_valid_d  = r_valid;
    w_period_d = r_period;
    w_stb_d    = 1'b0;
    if (w_timeout) begin
      w_valid_d  = 1'b0;
      w_run_d    = 3'd0;
      w_period_d = TimeoutCnt;
      w_stb_d    = 1'b1;
      // A coincident edge still serves as the new reference
      w_state_d  = r_edge ? StArm : StIdle;
    end else if (r_edge) begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StArm;
        end
        StArm: begin
          w_period_d = r_cnt;
          w_stb_d    = 1'b1;
          if (w_hit) begin
            w_run_d  = 3'd1;
            w_cand_d = w_cls;
            if (MatchCnt == 3'd1) begin
              w_state_d = StLock;
              w_note_d  = w_cls;
              w_valid_d = 1'b1;
            end else begin
              w_state_d = StTrack;
            end
          end
        end
        StTrack: begin
          w_period_d = r_cnt;
          w_stb_d    = 1'b1;
          if (w_hit && w_cls == r_cand) begin
            w_run_d = w_run_inc;
            if (w_run_inc == MatchCnt) begin
              w_state_d = StLock;
              w_note_d  = r_cand;
              w_valid_d = 1'b1;
            end
          end else if (w_hit) begin
            w_cand_d = w_cls;
            w_run_d  = 3'd1;
          end else begin
            w_state_d = StArm;
            w_run_d   = 3'd0;
          end
        end
        StLock: begin
          w_period_d = r_cnt;
          w_stb_d    = 1'b1;
          if (w_hit && w_cls != r_note) begin
            w_cand_d = w_cls;
            w_run_d  = 3'd1;
            if (MatchCnt == 3'd1) begin
              // Single-period lock re-locks immediately on the new note
              w_note_d = w_cls;
            end else begin
              w_valid_d = 1'b0;
              w_state_d = StTrack;
            end
          end else if (!w_hit) begin
            w_valid_d = 1'b0;
            w_run_d   = 3'd0;
            w_state_d = StArm;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // State, decoded note and period registers
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      r_state  <= StIdle;
      r_run    <= 3'd0;
      r_cand   <= 2'b00;
      r_note   <= 2'b00;
      r_valid  <= 1'b0;
      r_period <= '0;
      r_stb    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_run    <= w_run_d;
      r_cand   <= w_cand_d;
      r_note   <= w_note_d;
      r_valid  <= w_valid_d;
      r_period <= w_period_d;
      r_stb    <= w_stb_d;
    end
  end

  assign note       = r_note;
  assign note_valid = r_valid;
  assign period     = r_period;
  assign period_stb = r_stb;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with periods scaled down so a run stays short.
// Bands: C4 470..490, E4 370..390, Ab4 290..310, C5 230..250, timeout 625.
module tb_tone_decoder;

  localparam int unsigned TO  = 625;
  localparam int unsigned CHK = 6;

  logic        clk;
  logic        rst;
  logic        tone;
  logic [1:0]  note;
  logic        note_valid;
  logic [17:0] period;
  logic        period_stb;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  int stb_mark = 0;

  typedef struct {
    int unsigned p;
    logic        v;
    logic [1:0]  n;
  } vec_t;

  vec_t tbl [0:26];

  tone_decoder #(
    .P_C4     (480),
    .P_E4     (380),
    .P_AB4    (300),
    .P_C5     (240),
    .TOL      (10),
    .MATCH_CNT(3),
    .TIMEOUT  (TO)
  ) dut (
    .clk_50MHz   (clk),
    .reset_button(rst),
    .tone_in     (tone),
    .note        (note),
    .note_valid  (note_valid),
    .period      (period),
    .period_stb  (period_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes away from the active edge
  always @(negedge clk) if (period_stb) stb_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_stb(input string name, input int exp);
    chk(name, stb_cnt - stb_mark, exp);
    stb_mark = stb_cnt;
  endtask

  // Rising edge, then settle past the 4-cycle decode latency
  task automatic first_rise();
    tone = 1'b1;
    tick(CHK);
  endtask

  // Complete one period of p cycles ending CHK cycles after the next rise
  task automatic step(input int unsigned p);
    tick(p / 2 - CHK);
    tone = 1'b0;
    tick(p - p / 2);
    tone = 1'b1;
    tick(CHK);
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].p);
      chk($sformatf("v%0d_valid", i), note_valid, tbl[i].v);
      chk($sformatf("v%0d_note", i), note, tbl[i].n);
      chk($sformatf("v%0d_period", i), period, tbl[i].p);
      chk_stb($sformatf("v%0d_stb", i), 1);
    end
  endtask

  initial begin
    // C4 lock: valid after the 4th rising edge
    tbl[0]  = '{480, 1'b0, 2'b00};
    tbl[1]  = '{480, 1'b0, 2'b00};
    tbl[2]  = '{480, 1'b1, 2'b00};
    tbl[3]  = '{480, 1'b1, 2'b00};
    // Move to C5, lock
    tbl[4]  = '{240, 1'b0, 2'b00};
    tbl[5]  = '{240, 1'b0, 2'b00};
    tbl[6]  = '{240, 1'b1, 2'b11};
    // C5 -> E4: drop at first E4 period, re-lock after three
    tbl[7]  = '{380, 1'b0, 2'b11};
    tbl[8]  = '{380, 1'b0, 2'b11};
    tbl[9]  = '{380, 1'b1, 2'b01};
    // Out-of-band period drops to ARM
    tbl[10] = '{400, 1'b0, 2'b01};
    tbl[11] = '{300, 1'b0, 2'b01};
    tbl[12] = '{300, 1'b0, 2'b01};
    tbl[13] = '{300, 1'b1, 2'b10};
    // Ab4 band edges
    tbl[14] = '{290, 1'b1, 2'b10};
    tbl[15] = '{310, 1'b1, 2'b10};
    tbl[16] = '{289, 1'b0, 2'b10};
    tbl[17] = '{311, 1'b0, 2'b10};
    tbl[18] = '{300, 1'b0, 2'b10};
    tbl[19] = '{300, 1'b0, 2'b10};
    tbl[20] = '{300, 1'b1, 2'b10};
    // After timeout: re-lock on E4
    tbl[21] = '{380, 1'b0, 2'b10};
    tbl[22] = '{380, 1'b0, 2'b10};
    tbl[23] = '{380, 1'b1, 2'b01};
    // After mid-period reset: lock needs MATCH_CNT+1 edges
    tbl[24] = '{380, 1'b0, 2'b00};
    tbl[25] = '{380, 1'b0, 2'b00};
    tbl[26] = '{380, 1'b1, 2'b01};

    rst  = 1'b1;
    tone = 1'b0;
    tick(2);
    chk("reset_note", note, 0);
    chk("reset_valid", note_valid, 0);
    chk("reset_period", period, 0);
    chk("reset_stb", period_stb, 0);
    rst = 1'b0;
    tick(5);

    // First edge only arms
    first_rise();
    chk("arm_valid", note_valid, 0);
    chk("arm_period", period, 0);
    chk_stb("arm_stb", 0);

    run_vec(0, 20);

    // Tone stops while locked on Ab4
    tick(100);
    tone = 1'b0;
    tick(620 - CHK - 100);
    chk("to_pre_valid", note_valid, 1);
    chk_stb("to_pre_stb", 0);
    tick(20);
    chk("to_valid", note_valid, 0);
    chk("to_note", note, 2);
    chk("to_period", period, TO);
    chk_stb("to_stb", 1);
    tick(700);
    chk("to_hold_valid", note_valid, 0);
    chk_stb("to_hold_stb", 0);

    // From IDLE the next edge only arms
    first_rise();
    chk("rearm_valid", note_valid, 0);
    chk_stb("rearm_stb", 0);
    run_vec(21, 23);

    // Asynchronous reset mid-period while locked
    tick(100);
    rst = 1'b1;
    #2;
    chk("arst_note", note, 0);
    chk("arst_valid", note_valid, 0);
    chk("arst_period", period, 0);
    chk("arst_stb", period_stb, 0);
    tick(3);
    rst  = 1'b0;
    tone = 1'b0;
    tick(50);
    stb_mark = stb_cnt;
    first_rise();
    chk("post_rst_valid", note_valid, 0);
    chk("post_rst_period", period, 0);
    chk_stb("post_rst_stb", 0);
    run_vec(24, 26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
